// File: rtl/mem_responder_if.sv
// Bus bundle between the sequencer controller (master) and mem_responder (slave).
// Ports: addr, data_in, mem_rd, mem_wr (master->slave); data_out, data_valid,
//        wr_ack, busy, err, overrun (slave->master).
interface mem_responder_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
);
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data_in;
    logic              mem_rd;
    logic              mem_wr;
    logic [DWIDTH-1:0] data_out;
    logic              data_valid;
    logic              wr_ack;
    logic              busy;
    logic              err;
    logic              overrun;

    modport master (
        output addr, data_in, mem_rd, mem_wr,
        input  data_out, data_valid, wr_ack, busy, err, overrun
    );

    modport slave (
        input  addr, data_in, mem_rd, mem_wr,
        output data_out, data_valid, wr_ack, busy, err, overrun
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts mem_rd/mem_wr strobe edges, waits WAIT_STATES
// cycles, then returns read data (data_valid) or commits a write (wr_ack).
// Ports: clk, rst (async active-high), bus (mem_responder_if.slave).
// Optional: define MEM_RESP_PROTECT_EN to write-protect the top address quarter.
module mem_responder #(
    parameter int AWIDTH      = 5,
    parameter int DWIDTH      = 8,
    parameter int WAIT_STATES = 1
) (
    input logic             clk,
    input logic             rst,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_WRITE} state_t;

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [3:0] CNT_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state;
    logic [3:0]        cnt;
    logic              rd_q;
    logic              wr_q;
    logic              op_wr;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] data_q;
    logic [DWIDTH-1:0] mem [DEPTH];

    logic rd_rise;
    logic wr_rise;
    logic prot;
    logic we;

    // Strobe history resets high so a strobe held through reset is ignored.
    assign rd_rise = bus.mem_rd & ~rd_q;
    assign wr_rise = bus.mem_wr & ~wr_q;

`ifdef MEM_RESP_PROTECT_EN
    assign prot = (addr_q[AWIDTH-1 -: 2] == 2'b11);
`else
    assign prot = 1'b0;
`endif

    // Derived from the live state, so an async reset in WRITE cancels the commit.
    assign we = (state == S_WRITE) && !prot;

    always_ff @(posedge clk) begin
        if (we)
            mem[addr_q] <= data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= 4'd0;
            rd_q           <= 1'b1;
            wr_q           <= 1'b1;
            op_wr          <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.wr_ack     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            rd_q           <= bus.mem_rd;
            wr_q           <= bus.mem_wr;
            bus.data_valid <= 1'b0;
            bus.wr_ack     <= 1'b0;
            bus.err        <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (rd_rise && wr_rise) begin
                        bus.err <= 1'b1;
                    end else if (rd_rise || wr_rise) begin
                        op_wr    <= wr_rise;
                        addr_q   <= bus.addr;
                        data_q   <= bus.data_in;
                        cnt      <= CNT_LOAD;
                        bus.busy <= 1'b1;
                        if (WAIT_STATES > 0)
                            state <= S_WAIT;
                        else
                            state <= wr_rise ? S_WRITE : S_READ;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0)
                        state <= op_wr ? S_WRITE : S_READ;
                    else
                        cnt <= cnt - 4'd1;
                end
                S_READ: begin
                    bus.data_out   <= mem[addr_q];
                    bus.data_valid <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= S_IDLE;
                end
                S_WRITE: begin
                    bus.wr_ack <= !prot;
                    bus.err    <= prot;
                    bus.busy   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Edges while an access is in flight are dropped, never queued.
            if (state != S_IDLE && (rd_rise || wr_rise))
                bus.overrun <= 1'b1;
        end
    end
endmodule
